// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage is the master; memory answers with rdata/valid.
interface fetch_unit_if #(
   parameter int W = 32
);
   logic         req;
   logic [W-1:0] addr;
   logic [W-1:0] rdata;
   logic         valid;

   modport master (
      output req,
      output addr,
      input  rdata,
      input  valid
   );

   modport slave (
      input  req,
      input  addr,
      output rdata,
      output valid
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time and
// holds it for decode until consumed, then steps to PC+4 or PC+ImmOp.
module fetch_unit #(
   parameter int           W        = 32,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         PCsrc,
   input  logic [W-1:0] ImmOp,
   input  logic         stall,
   fetch_unit_if.master imem,
   output logic [W-1:0] instr,
   output logic         instr_valid,
   output logic [W-1:0] PC,
   output logic         fault,
   output logic [W-1:0] instr_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] next_pc;
   logic         misaligned;
   logic         consume;
   logic         take;

   assign next_pc    = PCsrc ? PC + ImmOp : PC + W'(4);
   assign misaligned = |next_pc[1:0];
   assign consume    = (state == ISSUE) && !stall;
   assign take       = (state == FETCH) && imem.valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   // Next-state: fetch until data arrives, issue until consumed,
   // halt for good on a misaligned target
   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH:   if (imem.valid) state_nxt = ISSUE;
         ISSUE:   if (!stall) state_nxt = misaligned ? HALT : FETCH;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      imem.req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state)
         FETCH:   imem.req    = 1'b1;
         ISSUE:   instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign imem.addr = PC;

   // Datapath: latch the fetched word, advance PC and count on consume
   always_ff @(posedge clk) begin
      if (rst) begin
         PC          <= RESET_PC;
         instr       <= '0;
         fault       <= 1'b0;
         instr_count <= '0;
      end else begin
         if (take) instr <= imem.rdata;
         if (consume) begin
            instr_count <= instr_count + W'(1);
            if (misaligned) fault <= 1'b1;
            else            PC    <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the words
// returned by the memory model until the stage hands them to decode.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        stall;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic        fault;
   logic [31:0] instr_count;

   fetch_unit_if #(.W(32)) imem ();

   fetch_unit #(.W(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .stall       (stall),
      .imem        (imem),
      .instr       (instr),
      .instr_valid (instr_valid),
      .PC          (PC),
      .fault       (fault),
      .instr_count (instr_count)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;
   logic        exp_fault;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One fetch: lat idle cycles, then a single valid pulse
   task automatic fetch(input int lat);
      chk("fetch_req", 32'(imem.req), 32'd1);
      chk("fetch_addr", imem.addr, exp_pc);
      chk("fetch_ivalid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < lat; i++) begin
         imem.valid = 1'b0;
         @(negedge clk);
         chk("wait_req", 32'(imem.req), 32'd1);
         chk("wait_ivalid", 32'(instr_valid), 32'd0);
      end
      imem.valid = 1'b1;
      imem.rdata = mem_word(exp_pc);
      sb.push_back(imem.rdata);
      @(negedge clk);
      imem.valid = 1'b0;
      imem.rdata = 32'hBAD0_BAD0;
   endtask

   // Hold in ISSUE for stalls cycles, then consume with pcsrc/imm
   task automatic consume(input int stalls, input logic pcsrc,
                          input logic [31:0] imm);
      logic [31:0] nxt;
      logic [31:0] exp_instr;
      exp_instr = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      for (int i = 0; i < stalls; i++) begin
         stall = 1'b1;
         PCsrc = 1'b1;
         ImmOp = 32'd6;
         chk("stall_ivalid", 32'(instr_valid), 32'd1);
         chk("stall_req", 32'(imem.req), 32'd0);
         chk("stall_instr", instr, exp_instr);
         chk("stall_pc", PC, exp_pc);
         chk("stall_cnt", instr_count, exp_cnt);
         @(negedge clk);
      end
      chk("issue_ivalid", 32'(instr_valid), 32'd1);
      chk("issue_req", 32'(imem.req), 32'd0);
      chk("issue_instr", instr, exp_instr);
      stall = 1'b0;
      PCsrc = pcsrc;
      ImmOp = imm;
      nxt   = pcsrc ? exp_pc + imm : exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
      if (nxt[1:0] != 2'b00) exp_fault = 1'b1;
      else                   exp_pc    = nxt;
      @(negedge clk);
      PCsrc = 1'b1;
      ImmOp = 32'd3;
      chk("post_cnt", instr_count, exp_cnt);
      chk("post_fault", 32'(fault), 32'(exp_fault));
      chk("post_pc", PC, exp_pc);
   endtask

   task automatic reset_checks();
      chk("rst_pc", PC, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ivalid", 32'(instr_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_cnt", instr_count, 32'd0);
   endtask

   // Directed sequence
   initial begin
      rst        = 1'b1;
      PCsrc      = 1'b0;
      ImmOp      = 32'h0;
      stall      = 1'b0;
      imem.valid = 1'b0;
      imem.rdata = 32'h0;
      exp_pc     = 32'h0;
      exp_cnt    = 32'h0;
      exp_fault  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_checks();
      rst = 1'b0;

      // Zero-latency stream: 0,4,8 then count 3
      for (int i = 0; i < 3; i++) begin
         fetch(0);
         consume(0, 1'b0, 32'h0);
      end
      chk("t1_cnt3", instr_count, 32'd3);

      // Branch backwards and sequential step
      fetch(0);
      consume(0, 1'b0, 32'h0);
      chk("t2_pc10", PC, 32'h10);
      fetch(1);
      consume(0, 1'b1, 32'hFFFF_FFF8);
      chk("t2_back", imem.addr, 32'h08);
      fetch(0);
      consume(0, 1'b1, 32'h8);
      fetch(2);
      consume(0, 1'b0, 32'h0);
      chk("t2_seq", imem.addr, 32'h14);

      // Three-cycle stall with a faulting target presented meanwhile
      fetch(0);
      consume(3, 1'b0, 32'h0);
      chk("t3_pc", PC, 32'h18);

      // Wrap past the top of the address space
      fetch(0);
      consume(0, 1'b1, 32'hFFFF_FFE4);
      chk("t5_top", imem.addr, 32'hFFFF_FFFC);
      fetch(1);
      consume(0, 1'b0, 32'h0);
      chk("t5_wrap", imem.addr, 32'h0);
      chk("t5_fault", 32'(fault), 32'd0);

      // Misaligned target: fault and halt
      fetch(0);
      consume(0, 1'b1, 32'h20);
      chk("t4_pc20", PC, 32'h20);
      fetch(0);
      consume(0, 1'b1, 32'd6);
      for (int i = 0; i < 4; i++) begin
         imem.valid = i[0];
         imem.rdata = 32'h1234_5678;
         stall      = 1'b0;
         @(negedge clk);
         chk("halt_fault", 32'(fault), 32'd1);
         chk("halt_req", 32'(imem.req), 32'd0);
         chk("halt_ivalid", 32'(instr_valid), 32'd0);
         chk("halt_pc", PC, 32'h20);
         chk("halt_cnt", instr_count, exp_cnt);
      end
      imem.valid = 1'b0;

      // Reset clears the halt; reset together with valid latches nothing
      rst        = 1'b1;
      imem.valid = 1'b1;
      imem.rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst        = 1'b0;
      imem.valid = 1'b0;
      reset_checks();
      exp_pc    = 32'h0;
      exp_cnt   = 32'h0;
      exp_fault = 1'b0;
      sb.delete();

      // Slow fetch abandoned by reset in its third wait cycle
      chk("t6_req", 32'(imem.req), 32'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t6_wait", 32'(instr_valid), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      reset_checks();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_idle_ivalid", 32'(instr_valid), 32'd0);
         chk("t6_idle_instr", instr, 32'h0);
      end
      fetch(0);
      consume(1, 1'b0, 32'h0);
      chk("t6_addr", imem.addr, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
